// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and widths for the data memory responder.
package dmem_pkg;
  localparam int DATA_W = 32;
  localparam int BE_W = 4;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
  typedef struct packed {
    logic              write;
    logic [31:0]       addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } req_t;
endpackage

// File: rtl/data_mem_array.sv
// data_mem_array: word RAM with per-lane write enables and a registered read port.
module data_mem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int AW = $clog2(DEPTH_WORDS)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [BE_W-1:0]   be_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < BE_W; i++)
      if (we_i && be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
    if (re_i) rdata_o <= mem_q[addr_i];
  end
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: one-at-a-time load/store responder with configurable wait states.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  req_t              req_q, req_d;
  logic              err_q, err_d, ok_q, ok_d;
  logic              accept, access, hs, fault;
  logic [DATA_W-1:0] ram_rdata;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      err_q   <= 1'b0;
      ok_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      err_q   <= err_d;
      ok_q    <= ok_d;
    end
  end
  always_comb begin
    accept  = req_valid && state_q == IDLE;
    access  = state_q == WAIT && cnt_q == '0;
    hs      = state_q == RESP && resp_ready;
    fault   = |req_q.addr[1:0] || req_q.addr[31:2] >= 30'(DEPTH_WORDS);
    state_d = accept ? WAIT : access ? RESP : hs ? IDLE : state_q;
    cnt_d   = accept ? 4'(WAIT_CYCLES) : (state_q == WAIT && cnt_q != '0) ? cnt_q - 4'd1 : cnt_q;
    req_d   = accept ? '{req_write, req_addr, req_wdata, req_be} : req_q;
    err_d   = access ? fault : hs ? 1'b0 : err_q;
    // ok_q marks a successful load, so the RAM read port may drive resp_rdata
    ok_d    = access ? !fault && !req_q.write : hs ? 1'b0 : ok_q;
  end
  always_comb begin
    req_ready  = state_q == IDLE;
    resp_valid = state_q == RESP;
    resp_err   = err_q;
    resp_rdata = ok_q ? ram_rdata : '0;
  end
  data_mem_array #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_array (
    .clk_i   (clock),
    .we_i    (access && !fault && req_q.write),
    .re_i    (access && !fault && !req_q.write),
    .be_i    (req_q.be),
    .addr_i  (req_q.addr[AW+1:2]),
    .wdata_i (req_q.wdata),
    .rdata_o (ram_rdata)
  );
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed table, corner sequences and random traffic against a word-map model.
module tb_data_mem_responder;
  localparam int DEPTH = 256;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  logic valid_a, ready_a, write_a, rvalid_a, rready_a, err_a;
  logic [31:0] addr_a, wdata_a, rdata_a;
  logic [3:0] be_a;
  logic valid_b, ready_b, write_b, rvalid_b, rready_b, err_b;
  logic [31:0] addr_b, wdata_b, rdata_b;
  logic [3:0] be_b;
  int total = 0, passed = 0;
  logic [31:0] model_val [int];
  logic [3:0]  model_def [int];

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) dut (
    .clock(clk), .reset_n(rst_n), .req_valid(valid_a), .req_ready(ready_a),
    .req_write(write_a), .req_addr(addr_a), .req_wdata(wdata_a), .req_be(be_a),
    .resp_valid(rvalid_a), .resp_ready(rready_a), .resp_rdata(rdata_a), .resp_err(err_a));

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clock(clk), .reset_n(rst_n), .req_valid(valid_b), .req_ready(ready_b),
    .req_write(write_b), .req_addr(addr_b), .req_wdata(wdata_b), .req_be(be_b),
    .resp_valid(rvalid_b), .resp_ready(rready_b), .resp_rdata(rdata_b), .resp_err(err_b));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic is_fault(input logic [31:0] a);
    return a % 4 != 0 || a / 4 >= DEPTH;
  endfunction

  task automatic model_store(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    int idx;
    logic [31:0] v;
    logic [3:0] m;
    if (!w || is_fault(a)) return;
    idx = int'(a / 4);
    v = model_val.exists(idx) ? model_val[idx] : 32'h0;
    m = model_def.exists(idx) ? model_def[idx] : 4'h0;
    for (int b = 0; b < 4; b++)
      if (be[b]) begin
        v[8*b +: 8] = d[8*b +: 8];
        m[b] = 1'b1;
      end
    model_val[idx] = v;
    model_def[idx] = m;
  endtask

  task automatic do_txn(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                        input int bp, output logic [31:0] rd, output logic er, output int lat);
    @(negedge clk);
    chk("idle_ready", 32'(ready_a), 32'd1);
    valid_a = 1'b1; write_a = w; addr_a = a; wdata_a = d; be_a = be; rready_a = 1'b0;
    @(posedge clk); #1;
    valid_a = 1'b0; write_a = 1'($urandom); addr_a = $urandom; wdata_a = $urandom; be_a = 4'($urandom);
    lat = 0;
    while (rvalid_a !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = rdata_a;
    er = err_a;
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(rvalid_a), 32'd1);
      chk("bp_rdata", rdata_a, rd);
      chk("bp_ready", 32'(ready_a), 32'd0);
    end
    @(negedge clk);
    rready_a = 1'b1;
    @(posedge clk); #1;
    rready_a = 1'b0;
    chk("hs_drop", 32'(rvalid_a), 32'd0);
  endtask

  task automatic txn_b(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                       output logic [31:0] rd, output logic er);
    @(negedge clk);
    valid_b = 1'b1; write_b = w; addr_b = a; wdata_b = d; be_b = be;
    @(posedge clk); #1;
    valid_b = 1'b0;
    chk("b_not_yet", 32'(rvalid_b), 32'd0);
    @(posedge clk); #1;
    chk("b_valid", 32'(rvalid_b), 32'd1);
    rd = rdata_b;
    er = err_b;
    @(posedge clk); #1;
    chk("b_done", 32'(rvalid_b), 32'd0);
    chk("b_ready", 32'(ready_b), 32'd1);
  endtask

  typedef struct {
    logic w; logic [31:0] addr; logic [31:0] wdata; logic [3:0] be; int bp;
    logic [31:0] exp_rd; logic exp_err; logic cd;
  } vec_t;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    vec_t vq[$];
    logic [31:0] rd, exp_rd;
    logic er;
    int lat, idx;
    logic w;
    logic [31:0] a, d;
    logic [3:0] be;
    int r;
    rst_n = 1'b0;
    valid_a = 0; write_a = 0; addr_a = 0; wdata_a = 0; be_a = 0; rready_a = 0;
    valid_b = 0; write_b = 0; addr_b = 0; wdata_b = 0; be_b = 0; rready_b = 1;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(ready_a), 32'd1);
    chk("rst_rvalid", 32'(rvalid_a), 32'd0);
    chk("rst_rdata", rdata_a, 32'd0);
    chk("rst_err", 32'(err_a), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", 32'(ready_a), 32'd1);
    chk("idle_rvalid", 32'(rvalid_a), 32'd0);

    vq.push_back('{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 32'h0, 1'b0, 1'b1});
    vq.push_back('{1'b0, 32'h10, 32'h0, 4'h0, 0, 32'hDEADBEEF, 1'b0, 1'b1});
    vq.push_back('{1'b1, 32'h20, 32'hFFFFFFFF, 4'hF, 0, 32'h0, 1'b0, 1'b1});
    vq.push_back('{1'b1, 32'h20, 32'h00000012, 4'h1, 0, 32'h0, 1'b0, 1'b1});
    vq.push_back('{1'b0, 32'h20, 32'h0, 4'hF, 0, 32'hFFFFFF12, 1'b0, 1'b1});
    vq.push_back('{1'b1, 32'h0, 32'hA5A5A5A5, 4'hF, 0, 32'h0, 1'b0, 1'b1});
    vq.push_back('{1'b0, 32'h22, 32'h0, 4'hF, 0, 32'h0, 1'b1, 1'b1});
    vq.push_back('{1'b1, 32'(4 * DEPTH), 32'hCAFEF00D, 4'hF, 0, 32'h0, 1'b1, 1'b1});
    vq.push_back('{1'b1, 32'hFFFFFFFC, 32'h12345678, 4'hF, 2, 32'h0, 1'b1, 1'b1});
    vq.push_back('{1'b0, 32'h0, 32'h0, 4'h0, 5, 32'hA5A5A5A5, 1'b0, 1'b1});
    vq.push_back('{1'b1, 32'h20, 32'h0, 4'h0, 0, 32'h0, 1'b0, 1'b1});
    vq.push_back('{1'b0, 32'h20, 32'h0, 4'h0, 0, 32'hFFFFFF12, 1'b0, 1'b1});
    vq.push_back('{1'b1, 32'h30, 32'h11111111, 4'hF, 0, 32'h0, 1'b0, 1'b1});
    foreach (vq[i]) begin
      do_txn(vq[i].w, vq[i].addr, vq[i].wdata, vq[i].be, vq[i].bp, rd, er, lat);
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'd3);
      chk($sformatf("vec%0d_err", i), 32'(er), 32'(vq[i].exp_err));
      if (vq[i].cd) chk($sformatf("vec%0d_rdata", i), rd, vq[i].exp_rd);
      model_store(vq[i].w, vq[i].addr, vq[i].wdata, vq[i].be);
    end

    // reset one cycle after accept must abort the pending store
    @(negedge clk);
    valid_a = 1'b1; write_a = 1'b1; addr_a = 32'h30; wdata_a = 32'h55; be_a = 4'hF;
    @(posedge clk); #1;
    valid_a = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rwait_ready", 32'(ready_a), 32'd1);
    chk("rwait_rvalid", 32'(rvalid_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_txn(1'b0, 32'h30, 32'h0, 4'h0, 0, rd, er, lat);
    chk("rwait_rdata", rd, 32'h11111111);
    chk("rwait_err", 32'(er), 32'd0);

    // reset while a response is pending drops it
    @(negedge clk);
    valid_a = 1'b1; write_a = 1'b0; addr_a = 32'h10;
    @(posedge clk); #1;
    valid_a = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rresp_valid", 32'(rvalid_a), 32'd1);
    chk("rresp_rdata", rdata_a, 32'hDEADBEEF);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rresp_drop", 32'(rvalid_a), 32'd0);
    chk("rresp_zero", rdata_a, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rresp_ready", 32'(ready_a), 32'd1);

    txn_b(1'b1, 32'h8, 32'h12345678, 4'hF, rd, er);
    chk("b_st_rdata", rd, 32'd0);
    chk("b_st_err", 32'(er), 32'd0);
    txn_b(1'b0, 32'h8, 32'h0, 4'h0, rd, er);
    chk("b_ld_rdata", rd, 32'h12345678);
    chk("b_ld_err", 32'(er), 32'd0);
    txn_b(1'b0, 32'h9, 32'h0, 4'h0, rd, er);
    chk("b_flt_rdata", rd, 32'd0);
    chk("b_flt_err", 32'(er), 32'd1);

    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 9);
      a = r == 0 ? 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3)) :
          r == 1 ? 32'((DEPTH + $urandom_range(0, 1000)) * 4) : 32'($urandom_range(0, 15) * 4);
      w = 1'($urandom_range(0, 1));
      d = $urandom;
      be = 4'($urandom);
      do_txn(w, a, d, be, $urandom_range(0, 3), rd, er, lat);
      chk("rnd_lat", 32'(lat), 32'd3);
      chk("rnd_err", 32'(er), 32'(is_fault(a)));
      idx = int'(a / 4);
      if (w || is_fault(a)) chk("rnd_rdata", rd, 32'd0);
      else if (model_def.exists(idx) && model_def[idx] == 4'hF) begin
        exp_rd = model_val[idx];
        chk("rnd_rdata", rd, exp_rd);
      end
      model_store(w, a, d, be);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
